// File: rtl/exu_pkg.sv
// Shared definitions for the execute stage: bus layouts, ALU opcodes, memory access encodings.
package exu_pkg;

  localparam int unsigned AduExuBusWidth = 233;
  localparam int unsigned ExuWbuBusWidth = 154;

  localparam logic [5:0] AluOpAdd = 6'b110000;
  localparam logic [5:0] AluOpSub = 6'b110001;
  localparam logic [5:0] AluOpSll = 6'b100000;
  localparam logic [5:0] AluOpSrl = 6'b100001;
  localparam logic [5:0] AluOpSra = 6'b100011;
  localparam logic [5:0] AluOpXor = 6'b010110;
  localparam logic [5:0] AluOpOr  = 6'b011110;
  localparam logic [5:0] AluOpAnd = 6'b011000;

  localparam logic [3:0] MemReLb  = 4'b0101;
  localparam logic [3:0] MemReLbu = 4'b0001;
  localparam logic [3:0] MemReLh  = 4'b0111;
  localparam logic [3:0] MemReLhu = 4'b0011;
  localparam logic [3:0] MemReLw  = 4'b1111;
  localparam logic [3:0] MemWeSb  = 4'b0001;
  localparam logic [3:0] MemWeSh  = 4'b0011;
  localparam logic [3:0] MemWeSw  = 4'b1111;

  typedef struct packed {
    logic        res_from_compare;
    logic        compare_result;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic [31:0] snpc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rs2_value;
    logic [5:0]  alu_op;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic        csr_we;
    logic [3:0]  mem_re;
    logic [3:0]  mem_we;
    logic [4:0]  rd;
    logic        jmp_flag;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_value;
  } adu_exu_bus_t;

  // The two top bits are reserved and always zero.
  typedef struct packed {
    logic [1:0]  rsvd;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic        misalign;
    logic        gr_we;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic [31:0] pc_next_seq;
  } exu_wbu_bus_t;

  function automatic logic misaligned(input logic is_word, input logic is_half,
                                      input logic [1:0] off);
    return (is_word && (off != 2'b00)) || (is_half && off[0]);
  endfunction

endpackage

// File: rtl/exu_alu.sv
// Combinational integer ALU for the execute stage.
module exu_alu
  import exu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  alu_op_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_op_i)
      AluOpAdd: result_o = a_i + b_i;
      AluOpSub: result_o = a_i - b_i;
      AluOpSll: result_o = a_i << shamt;
      AluOpSrl: result_o = a_i >> shamt;
      AluOpSra: result_o = $unsigned($signed(a_i) >>> shamt);
      AluOpXor: result_o = a_i ^ b_i;
      AluOpOr:  result_o = a_i | b_i;
      AluOpAnd: result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/exu.sv
// Execute stage: captures one dispatched instruction, runs the ALU, performs load/store over a
// req/gnt/rvalid port and presents one result bundle to write-back.
module exu
  import exu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      adu_valid_i,
  input  logic [AduExuBusWidth-1:0] adu_exu_bus_i,
  output logic                      ready_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_wstrb_o,
  output logic [XLEN-1:0]           mem_addr_o,
  output logic [XLEN-1:0]           mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [XLEN-1:0]           mem_rdata_i,
  output logic [ExuWbuBusWidth-1:0] exu_wbu_bus_o,
  output logic                      valid_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StExec    = 2'd1;
  localparam logic [1:0] StMemReq  = 2'd2;
  localparam logic [1:0] StMemWait = 2'd3;

  adu_exu_bus_t bus_in, bus_q, bus_d;
  exu_wbu_bus_t wbu;
  logic [1:0]   state_q, state_d;
  logic [31:0]  alu_res, alu_res_q, alu_res_d;
  logic         in_is_mem, in_misalign;
  logic         cap_is_mem, cap_misalign;
  logic [1:0]   off;
  logic         in_req;
  logic [31:0]  ld_shift, ld_data, wb_data;
  logic         ld_sign;

  assign bus_in = adu_exu_bus_i;

  // The ALU sees the incoming bus so alignment is known at capture; its result is registered.
  exu_alu u_alu (
    .a_i      (bus_in.src1),
    .b_i      (bus_in.src2),
    .alu_op_i (bus_in.alu_op),
    .result_o (alu_res)
  );

  assign in_is_mem   = |{bus_in.mem_re, bus_in.mem_we};
  assign in_misalign = misaligned(bus_in.mem_re[3] | bus_in.mem_we[3],
                                  ~(bus_in.mem_re[3] | bus_in.mem_we[3]) &
                                  (bus_in.mem_re[1] | bus_in.mem_we[1]),
                                  alu_res[1:0]);

  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    alu_res_d = alu_res_q;
    case (state_q)
      StIdle: begin
        if (adu_valid_i) begin
          bus_d     = bus_in;
          alu_res_d = alu_res;
          state_d   = (in_is_mem && !in_misalign) ? StMemReq : StExec;
        end
      end
      StExec:    state_d = StIdle;
      StMemReq:  if (mem_gnt_i) state_d = StMemWait;
      StMemWait: if (mem_rvalid_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      bus_q     <= '0;
      alu_res_q <= '0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      alu_res_q <= alu_res_d;
    end
  end

  assign off    = alu_res_q[1:0];
  assign in_req = (state_q == StMemReq);

  assign ready_o     = (state_q == StIdle);
  assign valid_o     = (state_q == StExec) || ((state_q == StMemWait) && mem_rvalid_i);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & (|bus_q.mem_we);
  assign mem_wstrb_o = in_req ? (bus_q.mem_we << off) : 4'b0000;
  assign mem_addr_o  = {alu_res_q[31:2], 2'b00};
  assign mem_wdata_o = bus_q.rs2_value << {off, 3'b000};

  assign cap_is_mem   = |{bus_q.mem_re, bus_q.mem_we};
  assign cap_misalign = cap_is_mem &
                        misaligned(bus_q.mem_re[3] | bus_q.mem_we[3],
                                   ~(bus_q.mem_re[3] | bus_q.mem_we[3]) &
                                   (bus_q.mem_re[1] | bus_q.mem_we[1]),
                                   off);

  // Load data is taken straight from the response word in the rvalid cycle.
  always_comb begin
    ld_shift = mem_rdata_i >> {off, 3'b000};
    ld_sign  = bus_q.mem_re[2] & ~bus_q.mem_re[3];
    if (bus_q.mem_re[3]) begin
      ld_data = mem_rdata_i;
    end else if (bus_q.mem_re[1]) begin
      ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
    end else begin
      ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
    end
  end

  always_comb begin
    if (bus_q.res_from_mem) begin
      wb_data = ld_data;
    end else if (bus_q.res_from_csr) begin
      wb_data = bus_q.csr_value;
    end else if (bus_q.res_from_compare) begin
      wb_data = {31'b0, bus_q.compare_result};
    end else if (bus_q.jmp_flag) begin
      wb_data = bus_q.snpc;
    end else begin
      wb_data = alu_res_q;
    end
  end

  always_comb begin
    wbu              = '0;
    wbu.excp_flush   = bus_q.excp_flush;
    wbu.xret_flush   = bus_q.xret_flush;
    wbu.break_signal = bus_q.break_signal;
    wbu.misalign     = cap_misalign;
    wbu.gr_we        = bus_q.gr_we & ~cap_misalign;
    wbu.rd           = bus_q.rd;
    wbu.wb_data      = wb_data;
    wbu.csr_we       = bus_q.csr_we;
    wbu.csr_addr     = bus_q.csr_addr;
    wbu.csr_wdata    = bus_q.csr_wdata;
    wbu.jmp_flag     = bus_q.jmp_flag;
    wbu.jmp_target   = {alu_res_q[31:1], 1'b0};
    wbu.pc_next_seq  = bus_q.snpc;
  end

  assign exu_wbu_bus_o = wbu;

endmodule

// File: tb/tb_exu.sv
// Directed self-checking bench for the execute stage.
module tb_exu;
  import exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        adu_valid = 1'b0;
  logic [232:0] adu_bus = '0;
  logic        ready, mem_req, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [153:0] wbu_bus;
  logic        valid;
  exu_wbu_bus_t wb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign wb = wbu_bus;

  exu #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .adu_valid_i   (adu_valid),
    .adu_exu_bus_i (adu_bus),
    .ready_o       (ready),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_wstrb_o   (mem_wstrb),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .exu_wbu_bus_o (wbu_bus),
    .valid_o       (valid)
  );

  typedef struct {
    string       name;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  op;
    logic        csr;
    logic        cmp;
    logic        cmp_res;
    logic        jmp;
    logic [31:0] csr_value;
    logic [31:0] snpc;
    logic [4:0]  rd;
    logic [31:0] exp_wb;
    logic [31:0] exp_jt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [153:0] act, input logic [153:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one instruction from IDLE; returns just after the capture edge.
  task automatic issue(input adu_exu_bus_t b, input string nm);
    @(negedge clk);
    chk({nm, "_idle_ready"}, ready, 1);
    chk({nm, "_idle_valid"}, valid, 0);
    adu_bus   = b;
    adu_valid = 1'b1;
    @(negedge clk);
    adu_valid = 1'b0;
    #1;
  endtask

  task automatic run_load(input string nm, input logic [31:0] addr, input logic [3:0] re,
                          input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                          input logic [31:0] exp_wb);
    adu_exu_bus_t b;
    b = '0;
    b.src1         = addr;
    b.alu_op       = AluOpAdd;
    b.mem_re       = re;
    b.res_from_mem = 1'b1;
    b.gr_we        = 1'b1;
    b.rd           = 5'd7;
    issue(b, nm);
    chk({nm, "_req"}, mem_req, 1);
    chk({nm, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
    chk({nm, "_we"}, mem_we, 0);
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk); #1;
      chk({nm, "_req_hold"}, mem_req, 1);
      chk({nm, "_addr_hold"}, mem_addr, addr & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk({nm, "_req_gnt"}, mem_req, 1);
    for (int i = 1; i < rv_wait; i++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      chk({nm, "_wait_req"}, mem_req, 0);
      chk({nm, "_wait_valid"}, valid, 0);
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    #1;
    chk({nm, "_valid"}, valid, 1);
    chk({nm, "_wb_data"}, wb.wb_data, exp_wb);
    chk({nm, "_rd"}, wb.rd, 5'd7);
    chk({nm, "_gr_we"}, wb.gr_we, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk({nm, "_valid_drop"}, valid, 0);
    chk({nm, "_ready_back"}, ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    adu_exu_bus_t b;

    vecs[0]  = '{"add",  32'd5, 32'hFFFF_FFFD, AluOpAdd, 0, 0, 0, 0, 0, 32'h100, 5'd3,
                 32'd2, 32'd2};
    vecs[1]  = '{"sra",  32'h8000_0000, 32'd4, AluOpSra, 0, 0, 0, 0, 0, 32'h104, 5'd4,
                 32'hF800_0000, 32'hF800_0000};
    vecs[2]  = '{"srl",  32'h8000_0000, 32'd4, AluOpSrl, 0, 0, 0, 0, 0, 32'h108, 5'd5,
                 32'h0800_0000, 32'h0800_0000};
    vecs[3]  = '{"sub",  32'd3, 32'd5, AluOpSub, 0, 0, 0, 0, 0, 32'h10C, 5'd6,
                 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    vecs[4]  = '{"sll",  32'd1, 32'h3F, AluOpSll, 0, 0, 0, 0, 0, 32'h110, 5'd7,
                 32'h8000_0000, 32'h8000_0000};
    vecs[5]  = '{"xor",  32'hF0F0_F0F0, 32'hFF00_FF00, AluOpXor, 0, 0, 0, 0, 0, 32'h114, 5'd8,
                 32'h0FF0_0FF0, 32'h0FF0_0FF0};
    vecs[6]  = '{"or",   32'hF0, 32'h0F, AluOpOr, 0, 0, 0, 0, 0, 32'h118, 5'd9,
                 32'hFF, 32'hFE};
    vecs[7]  = '{"and",  32'hF0F0_F0F0, 32'hFF00_FF00, AluOpAnd, 0, 0, 0, 0, 0, 32'h11C, 5'd10,
                 32'hF000_F000, 32'hF000_F000};
    vecs[8]  = '{"badop", 32'd7, 32'd9, 6'b111111, 0, 0, 0, 0, 0, 32'h120, 5'd11,
                 32'd0, 32'd0};
    vecs[9]  = '{"csr",  32'd1, 32'd2, AluOpAdd, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h124, 5'd12,
                 32'hDEAD_BEEF, 32'd2};
    vecs[10] = '{"cmp",  32'd5, 32'd5, AluOpAdd, 0, 1, 1, 0, 0, 32'h128, 5'd13,
                 32'd1, 32'd10};
    vecs[11] = '{"jalr", 32'h4000, 32'd1, AluOpAdd, 0, 0, 0, 1, 0, 32'h104, 5'd1,
                 32'h104, 32'h4000};
    vecs[12] = '{"prio", 32'h4000, 32'd1, AluOpAdd, 1, 1, 1, 1, 32'h55, 32'h130, 5'd14,
                 32'h55, 32'h4000};
    vecs[13] = '{"cmpjmp", 32'h4000, 32'd1, AluOpAdd, 0, 1, 0, 1, 0, 32'h134, 5'd15,
                 32'd0, 32'h4000};

    // Reset state
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_wbu", wbu_bus, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single-cycle ops, issued back-to-back
    for (int i = 0; i < 14; i++) begin
      b = '0;
      b.src1             = vecs[i].src1;
      b.src2             = vecs[i].src2;
      b.alu_op           = vecs[i].op;
      b.res_from_csr     = vecs[i].csr;
      b.res_from_compare = vecs[i].cmp;
      b.compare_result   = vecs[i].cmp_res;
      b.jmp_flag         = vecs[i].jmp;
      b.csr_value        = vecs[i].csr_value;
      b.snpc             = vecs[i].snpc;
      b.rd               = vecs[i].rd;
      b.gr_we            = 1'b1;
      issue(b, vecs[i].name);
      chk({vecs[i].name, "_valid"}, valid, 1);
      chk({vecs[i].name, "_ready"}, ready, 0);
      chk({vecs[i].name, "_req"}, mem_req, 0);
      chk({vecs[i].name, "_wb_data"}, wb.wb_data, vecs[i].exp_wb);
      chk({vecs[i].name, "_jmp_target"}, wb.jmp_target, vecs[i].exp_jt);
      chk({vecs[i].name, "_pc_next"}, wb.pc_next_seq, vecs[i].snpc);
      chk({vecs[i].name, "_rd"}, wb.rd, vecs[i].rd);
      chk({vecs[i].name, "_gr_we"}, wb.gr_we, 1);
      chk({vecs[i].name, "_misalign"}, wb.misalign, 0);
      chk({vecs[i].name, "_jmp_flag"}, wb.jmp_flag, vecs[i].jmp);
    end

    // adu_valid while busy is ignored
    b = '0;
    b.src1 = 32'd1; b.src2 = 32'd1; b.alu_op = AluOpAdd; b.rd = 5'd2; b.gr_we = 1'b1;
    issue(b, "busy");
    chk("busy_valid", valid, 1);
    adu_valid = 1'b1;
    adu_bus[0] = 1'b1;
    @(negedge clk);
    adu_valid = 1'b0;
    #1;
    chk("busy_ignored_ready", ready, 1);
    @(negedge clk); #1;
    chk("busy_ignored_valid", valid, 0);

    // Loads with various wait states
    run_load("lb",  32'h1003, MemReLb,  32'h80AA_BBCC, 2, 3, 32'hFFFF_FF80);
    run_load("lbu", 32'h1001, MemReLbu, 32'h80AA_BBCC, 0, 1, 32'h0000_00BB);
    run_load("lhu", 32'h1002, MemReLhu, 32'h8001_BEEF, 0, 1, 32'h0000_8001);
    run_load("lh",  32'h1000, MemReLh,  32'h1234_F00D, 1, 2, 32'hFFFF_F00D);
    run_load("lw",  32'h1004, MemReLw,  32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);

    // Halfword store at offset 2
    b = '0;
    b.src1 = 32'h2000; b.src2 = 32'd2; b.alu_op = AluOpAdd;
    b.rs2_value = 32'h1234_ABCD; b.mem_we = MemWeSh;
    issue(b, "sh");
    chk("sh_req", mem_req, 1);
    chk("sh_we", mem_we, 1);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCD_0000);
    chk("sh_addr", mem_addr, 32'h2000);
    chk("sh_valid_early", valid, 0);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("sh_wdata_hold", mem_wdata, 32'hABCD_0000);
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("sh_valid", valid, 1);
    chk("sh_gr_we", wb.gr_we, 0);
    chk("sh_req_off", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("sh_valid_drop", valid, 0);
    chk("sh_wstrb_idle", mem_wstrb, 0);

    // Misaligned word load and halfword store skip memory
    b = '0;
    b.src1 = 32'h3000; b.src2 = 32'd1; b.alu_op = AluOpAdd;
    b.mem_re = MemReLw; b.res_from_mem = 1'b1; b.gr_we = 1'b1; b.rd = 5'd9;
    issue(b, "lw_mis");
    chk("lw_mis_req", mem_req, 0);
    chk("lw_mis_valid", valid, 1);
    chk("lw_mis_flag", wb.misalign, 1);
    chk("lw_mis_gr_we", wb.gr_we, 0);
    b = '0;
    b.src1 = 32'h2001; b.alu_op = AluOpAdd; b.mem_we = MemWeSh; b.gr_we = 1'b1;
    issue(b, "sh_mis");
    chk("sh_mis_req", mem_req, 0);
    chk("sh_mis_valid", valid, 1);
    chk("sh_mis_flag", wb.misalign, 1);

    // Reset while waiting for rvalid, then a stray rvalid
    b = '0;
    b.src1 = 32'h5000; b.alu_op = AluOpAdd; b.mem_re = MemReLw;
    b.res_from_mem = 1'b1; b.gr_we = 1'b1; b.rd = 5'd9;
    issue(b, "rstw");
    chk("rstw_req", mem_req, 1);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rstw_ready", ready, 1);
    chk("rstw_valid", valid, 0);
    chk("rstw_req_off", mem_req, 0);
    chk("rstw_wbu", wbu_bus, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    #1;
    chk("late_rvalid_valid", valid, 0);
    chk("late_rvalid_ready", ready, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_after", valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exu.md
Name: exu

Overview:
- Execute stage directly downstream of the decode/dispatch stage.
- Registers the dispatch bus and evaluates the ALU result, branch/jump target and write-back data.
- Performs load/store through a req/gnt/rvalid data-memory port; non-memory ops complete in one cycle.
- Emits one registered result bundle per instruction to the write-back stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous, active-low reset (asserted when 0).
adu_valid_i  in  1  dispatch bus valid; sampled only when ready_o=1.
adu_exu_bus_i  in  `ADU_EXU_BUS_WIDTH (233)  fields MSB first: res_from_compare, compare_result, excp_flush, xret_flush, break_signal, snpc[32], src1[32], src2[32], rs2_value[32], alu_op[6], res_from_mem, res_from_csr, gr_we, csr_we, mem_re[4], mem_we[4], rd[5], jmp_flag, csr_addr[12], csr_wdata[32], csr_value[32].
ready_o  out  1  can accept a new instruction; 1 only in IDLE.
mem_req_o  out  1  data memory request.
mem_we_o  out  1  1 = store.
mem_wstrb_o  out  4  byte strobes, shifted by addr[1:0].
mem_addr_o  out  32  word-aligned address: {alu_res[31:2],2'b00}.
mem_wdata_o  out  32  rs2_value shifted left by 8*addr[1:0].
mem_gnt_i  in  1  request accepted.
mem_rvalid_i  in  1  response (load data or store ack).
mem_rdata_i  in  32  load data word.
exu_wbu_bus_o  out  `EXU_WBU_BUS_WIDTH (154)  fields: excp_flush, xret_flush, break_signal, misalign, gr_we, rd[5], wb_data[32], csr_we, csr_addr[12], csr_wdata[32], jmp_flag, jmp_target[32], pc_next_seq[32].
valid_o  out  1  result valid for exactly one cycle.

Behaviour:
- Reset: state=IDLE, ready_o=1, valid_o=0, mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, captured bus=0, exu_wbu_bus_o=0.
- FSM states: IDLE, EXEC, MEM_REQ, MEM_WAIT.
- IDLE:
  - If adu_valid_i, capture the bus.
  - If mem_re|mem_we is nonzero and the access is aligned, go to MEM_REQ; otherwise go to EXEC.
- EXEC: valid_o=1 for this cycle, with the bundle built from the captured bus; return to IDLE. Latency is 1 cycle from capture.
- MEM_REQ: mem_req_o=1; all mem_* outputs stay stable until mem_gnt_i. On gnt go to MEM_WAIT.
- MEM_WAIT: on mem_rvalid_i, register the load result and assert valid_o in the same cycle; return to IDLE. A gnt and rvalid in the same cycle are illegal (rvalid arrives ≥1 cycle after gnt).
- ALU (src1 a, src2 b, shamt=b[4:0]), alu_op encoding:
  - 110000 add; 110001 sub.
  - 100000 sll; 100001 srl; 100011 sra.
  - 010110 xor; 011110 or; 011000 and.
  - Any other code returns 0.
- wb_data priority:
  1. res_from_mem: extracted load data.
  2. res_from_csr: csr_value.
  3. res_from_compare: {31'b0, compare_result}.
  4. jmp_flag: snpc.
  5. Otherwise the ALU result.
- Load extraction:
  - size = mem_re[3] ? word : mem_re[1] ? half : byte.
  - sign-extend when mem_re[2] & ~mem_re[3].
  - Byte/half is selected by addr[1:0].
- jmp_target = alu_res with bit0 cleared. pc_next_seq = snpc.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - No memory request is issued; goes through EXEC with misalign=1 and gr_we=0.
- Stores: go through the MEM states; valid_o on the ack. wb_data is don't-care; gr_we is passed as captured (decode clears it).
- Back-to-back: a new instruction is accepted in the cycle after valid_o; the minimum spacing of valid_o is 2 cycles.
- adu_valid_i while ready_o=0: ignored. Upstream must hold the bus.
- Reset mid-operation: async clear to IDLE. A late mem_rvalid_i arriving in IDLE is ignored.

Decomposition:
- Shared header riscv_param.vh: ADU_EXU_/EXU_WBU_BUS_WIDTH, the ALU_OP_* encodings, and the MEM_RE_* encodings.
- One combinational sub-module, exu_alu (a, b, alu_op -> result).
- The FSM, load align/extend and store shifting stay in exu.

Test Plan:
1. add: src1=5, src2=0xFFFFFFFD, alu_op=110000, gr_we=1, rd=3 -> valid_o 1 cycle after capture, wb_data=2, rd=3.
2. sra: src1=0x80000000, src2=4, alu_op=100011 -> wb_data=0xF8000000. srl gives 0x08000000.
3. lb: alu_res=0x1003, mem_re=0101, rdata=0x80AABBCC, gnt after 2 wait cycles, rvalid 3 cycles later -> addr=0x1000, wb_data=0xFFFFFF80, valid_o in the rvalid cycle, req stable while waiting.
4. sh: alu_res=0x2002, rs2=0x1234ABCD, mem_we=0011 -> wstrb=1100, wdata=0xABCD0000, mem_we_o=1, valid_o on ack.
5. lw: alu_res=0x3001 -> no mem_req_o, valid_o next cycle with misalign=1, gr_we=0.
6. Reset during MEM_WAIT, then rvalid pulse after release -> valid_o stays 0, ready_o=1. jalr: alu_res=0x4001 -> jmp_target=0x4000, wb_data=snpc.
